// File: rtl/sram_1rw_arbiter.sv
// ---------------------------------------------------------------------------
// sram_1rw_arbiter
//
// Shares one single-port 1RW SRAM macro between two requesters (p0, p1)
// using round-robin arbitration. At most one access is issued per cycle,
// every macro input pin is driven from a flop, and read data is routed back
// to the requester that issued the read with a fixed latency.
//
// Ports
//   clk, rst_n          clock (also the macro clock) / async active-low reset
//   pN_req_valid        request valid (N = 0, 1)
//   pN_req_ready        grant: request accepted this cycle
//   pN_req_we           1 = write, 0 = read
//   pN_req_addr         word address
//   pN_req_wdata        write data
//   pN_rsp_valid        one-cycle pulse, read data valid
//   pN_rsp_rdata        read data, meaningful only while pN_rsp_valid = 1
//   sram_a/csb/web/oeb/i  registered macro pins (csb/web/oeb active low)
//   sram_o              macro read data, tri-stated while sram_oeb = 1
//
// Timing: grant in cycle T -> macro pins in T+1 -> read data on sram_o in
// T+2 -> rsp pulse in T+2+OUT_REG.
// ---------------------------------------------------------------------------
module sram_1rw_arbiter #(
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 48,
   parameter int OUT_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic              p0_req_we,
   input  logic [ADDR_W-1:0] p0_req_addr,
   input  logic [DATA_W-1:0] p0_req_wdata,
   output logic              p0_rsp_valid,
   output logic [DATA_W-1:0] p0_rsp_rdata,
   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic              p1_req_we,
   input  logic [ADDR_W-1:0] p1_req_addr,
   input  logic [DATA_W-1:0] p1_req_wdata,
   output logic              p1_rsp_valid,
   output logic [DATA_W-1:0] p1_rsp_rdata,
   output logic [ADDR_W-1:0] sram_a,
   output logic              sram_csb,
   output logic              sram_web,
   output logic              sram_oeb,
   output logic [DATA_W-1:0] sram_i,
   input  logic [DATA_W-1:0] sram_o
);

   // ptr = 0 gives p0 priority when both ports are valid, ptr = 1 gives p1
   logic              ptr;
   logic              grant0;
   logic              grant1;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Tag of the access currently on the macro pins (cycle T+1)
   logic              s1_read;
   logic              s1_port;
   // Port owning the data on sram_o (cycle T+2); read-ness is ~sram_oeb
   logic              s2_port;

   logic              hit0;
   logic              hit1;

   // Grant is purely combinational so a lone requester is accepted the
   // same cycle it raises valid; the two grants are mutually exclusive.
   always_comb begin
      grant0    = p0_req_valid & (~p1_req_valid | ~ptr);
      grant1    = p1_req_valid & (~p0_req_valid |  ptr);
      sel_we    = grant1 ? p1_req_we    : p0_req_we;
      sel_addr  = grant1 ? p1_req_addr  : p0_req_addr;
      sel_wdata = grant1 ? p1_req_wdata : p0_req_wdata;
   end

   assign p0_req_ready = grant0;
   assign p1_req_ready = grant1;

   // Macro pins, priority pointer and the tag pipeline. sram_i only loads
   // on writes so reads leave the data bus untouched; a, web and i hold
   // across idle cycles and only csb deasserts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= 1'b0;
         sram_a   <= '0;
         sram_csb <= 1'b1;
         sram_web <= 1'b1;
         sram_oeb <= 1'b1;
         sram_i   <= '0;
         s1_read  <= 1'b0;
         s1_port  <= 1'b0;
         s2_port  <= 1'b0;
      end else begin
         if (grant0 | grant1) begin
            ptr      <= grant0;
            sram_csb <= 1'b0;
            sram_web <= ~sel_we;
            sram_a   <= sel_addr;
            if (sel_we) begin
               sram_i <= sel_wdata;
            end
         end else begin
            sram_csb <= 1'b1;
         end
         s1_read  <= (grant0 | grant1) & ~sel_we;
         s1_port  <= grant1;
         sram_oeb <= ~s1_read;
         s2_port  <= s1_port;
      end
   end

   // Read data is on sram_o exactly while oeb is low; route it by port tag
   assign hit0 = ~sram_oeb & ~s2_port;
   assign hit1 = ~sram_oeb &  s2_port;

   generate
      if (OUT_REG != 0) begin : g_out_reg
         // Registered response: capture sram_o at the end of the data cycle
         // and pulse valid one cycle later. Data only updates on a hit so it
         // stays stable between pulses.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               p0_rsp_valid <= 1'b0;
               p1_rsp_valid <= 1'b0;
               p0_rsp_rdata <= '0;
               p1_rsp_rdata <= '0;
            end else begin
               p0_rsp_valid <= hit0;
               p1_rsp_valid <= hit1;
               if (hit0) begin
                  p0_rsp_rdata <= sram_o;
               end
               if (hit1) begin
                  p1_rsp_rdata <= sram_o;
               end
            end
         end
      end else begin : g_out_comb
         // Combinational response straight from the macro output
         assign p0_rsp_valid = hit0;
         assign p1_rsp_valid = hit1;
         assign p0_rsp_rdata = sram_o;
         assign p1_rsp_rdata = sram_o;
      end
   endgenerate

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_1rw_arbiter
//
// Drives one shared set of requests into two arbiter instances, one with a
// registered response stage and one combinational, each attached to its own
// behavioural SRAM macro. Expected values are hand-computed constants or
// derived from the known initial memory pattern.
// ---------------------------------------------------------------------------
module tb_sram_1rw_arbiter;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 48;
   localparam logic [DATA_W-1:0] FLOAT_WORD = 48'hDEAD_DEAD_DEAD;

   logic              clk;
   logic              rst_n;
   logic              p0_req_valid;
   logic              p0_req_we;
   logic [ADDR_W-1:0] p0_req_addr;
   logic [DATA_W-1:0] p0_req_wdata;
   logic              p1_req_valid;
   logic              p1_req_we;
   logic [ADDR_W-1:0] p1_req_addr;
   logic [DATA_W-1:0] p1_req_wdata;

   // Registered-response instance
   logic              r_p0_ready, r_p1_ready, r_p0_rsp_valid, r_p1_rsp_valid;
   logic [DATA_W-1:0] r_p0_rsp_rdata, r_p1_rsp_rdata;
   logic [ADDR_W-1:0] r_a;
   logic              r_csb, r_web, r_oeb;
   logic [DATA_W-1:0] r_i, r_o, r_rd;
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   // Combinational-response instance
   logic              c_p0_ready, c_p1_ready, c_p0_rsp_valid, c_p1_rsp_valid;
   logic [DATA_W-1:0] c_p0_rsp_rdata, c_p1_rsp_rdata;
   logic [ADDR_W-1:0] c_a;
   logic              c_csb, c_web, c_oeb;
   logic [DATA_W-1:0] c_i, c_o, c_rd;
   logic [DATA_W-1:0] c_mem [2**ADDR_W];

   int tests_run = 0;
   int tests_failed = 0;

   sram_1rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_REG(1)) u_dut_reg (
      .clk(clk), .rst_n(rst_n),
      .p0_req_valid(p0_req_valid), .p0_req_ready(r_p0_ready), .p0_req_we(p0_req_we),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
      .p0_rsp_valid(r_p0_rsp_valid), .p0_rsp_rdata(r_p0_rsp_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(r_p1_ready), .p1_req_we(p1_req_we),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
      .p1_rsp_valid(r_p1_rsp_valid), .p1_rsp_rdata(r_p1_rsp_rdata),
      .sram_a(r_a), .sram_csb(r_csb), .sram_web(r_web), .sram_oeb(r_oeb),
      .sram_i(r_i), .sram_o(r_o)
   );

   sram_1rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_REG(0)) u_dut_comb (
      .clk(clk), .rst_n(rst_n),
      .p0_req_valid(p0_req_valid), .p0_req_ready(c_p0_ready), .p0_req_we(p0_req_we),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
      .p0_rsp_valid(c_p0_rsp_valid), .p0_rsp_rdata(c_p0_rsp_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(c_p1_ready), .p1_req_we(p1_req_we),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
      .p1_rsp_valid(c_p1_rsp_valid), .p1_rsp_rdata(c_p1_rsp_rdata),
      .sram_a(c_a), .sram_csb(c_csb), .sram_web(c_web), .sram_oeb(c_oeb),
      .sram_i(c_i), .sram_o(c_o)
   );

   // Clock: 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Initial memory pattern: word k holds {16'hC0DE, 32'(k)}
   function automatic logic [DATA_W-1:0] initWord(input int addr);
      return {16'hC0DE, 32'(addr)};
   endfunction

   // Behavioural macros: sample pins on the rising edge, read data appears
   // after the edge and is only driven while oeb is low (FLOAT_WORD stands
   // in for the tri-stated bus).
   initial begin
      for (int k = 0; k < 2**ADDR_W; k++) r_mem[k] = initWord(k);
      r_rd = '0;
      forever begin
         @(posedge clk);
         if (!r_csb) begin
            if (!r_web) r_mem[r_a] <= r_i;
            else        r_rd <= r_mem[r_a];
         end
      end
   end
   assign r_o = r_oeb ? FLOAT_WORD : r_rd;

   initial begin
      for (int k = 0; k < 2**ADDR_W; k++) c_mem[k] = initWord(k);
      c_rd = '0;
      forever begin
         @(posedge clk);
         if (!c_csb) begin
            if (!c_web) c_mem[c_a] <= c_i;
            else        c_rd <= c_mem[c_a];
         end
      end
   end
   assign c_o = c_oeb ? FLOAT_WORD : c_rd;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive both request ports, then let combinational grants settle
   task automatic applyStimulus(input logic v0, input logic we0, input int a0,
                                input logic [DATA_W-1:0] d0,
                                input logic v1, input logic we1, input int a1,
                                input logic [DATA_W-1:0] d1);
      p0_req_valid = v0;
      p0_req_we    = we0;
      p0_req_addr  = ADDR_W'(a0);
      p0_req_wdata = d0;
      p1_req_valid = v1;
      p1_req_we    = we1;
      p1_req_addr  = ADDR_W'(a1);
      p1_req_wdata = d1;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0);
   endtask

   initial begin
      int j;
      int exp_addr;
      logic exp_p0;
      logic exp_p1;

      rst_n = 1'b0;
      idle();

      // Reset state
      repeat (3) tick();
      checkOutput("rst_csb", 64'(r_csb), 64'd1);
      checkOutput("rst_web", 64'(r_web), 64'd1);
      checkOutput("rst_oeb", 64'(r_oeb), 64'd1);
      checkOutput("rst_a", 64'(r_a), 64'd0);
      checkOutput("rst_i", 64'(r_i), 64'd0);
      checkOutput("rst_r_p0_rsp_valid", 64'(r_p0_rsp_valid), 64'd0);
      checkOutput("rst_r_p1_rsp_valid", 64'(r_p1_rsp_valid), 64'd0);
      checkOutput("rst_r_p0_rdata", 64'(r_p0_rsp_rdata), 64'd0);
      checkOutput("rst_c_p0_rsp_valid", 64'(c_p0_rsp_valid), 64'd0);
      checkOutput("rst_c_p1_rsp_valid", 64'(c_p1_rsp_valid), 64'd0);
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_csb", 64'(r_csb), 64'd1);
      checkOutput("post_rst_oeb", 64'(c_oeb), 64'd1);

      // Write then read back on p0; first simultaneous request goes to p0
      applyStimulus(1'b1, 1'b1, 5, 48'hABCD_1234_5678, 1'b1, 1'b0, 9, '0);
      checkOutput("first_r_p0_ready", 64'(r_p0_ready), 64'd1);
      checkOutput("first_r_p1_ready", 64'(r_p1_ready), 64'd0);
      checkOutput("first_c_p0_ready", 64'(c_p0_ready), 64'd1);
      checkOutput("first_c_p1_ready", 64'(c_p1_ready), 64'd0);
      applyStimulus(1'b1, 1'b1, 5, 48'hABCD_1234_5678, 1'b0, 1'b0, 0, '0);
      checkOutput("wr_p0_ready", 64'(r_p0_ready), 64'd1);
      tick();
      checkOutput("wr_csb", 64'(r_csb), 64'd0);
      checkOutput("wr_web", 64'(r_web), 64'd0);
      checkOutput("wr_a", 64'(r_a), 64'd5);
      checkOutput("wr_i", 64'(r_i), 64'hABCD_1234_5678);
      applyStimulus(1'b1, 1'b0, 5, 48'h1111, 1'b0, 1'b0, 0, '0);
      checkOutput("rd_p0_ready", 64'(r_p0_ready), 64'd1);
      tick();
      checkOutput("rd_csb", 64'(r_csb), 64'd0);
      checkOutput("rd_web", 64'(r_web), 64'd1);
      checkOutput("rd_a", 64'(r_a), 64'd5);
      checkOutput("rd_i_hold", 64'(r_i), 64'hABCD_1234_5678);
      checkOutput("rd_oeb_issue", 64'(r_oeb), 64'd1);
      idle();
      tick();
      checkOutput("idle_csb", 64'(r_csb), 64'd1);
      checkOutput("rd_oeb_data", 64'(r_oeb), 64'd0);
      checkOutput("rd_c_p0_valid", 64'(c_p0_rsp_valid), 64'd1);
      checkOutput("rd_c_p0_rdata", 64'(c_p0_rsp_rdata), 64'hABCD_1234_5678);
      checkOutput("rd_c_p1_valid", 64'(c_p1_rsp_valid), 64'd0);
      checkOutput("rd_r_p0_early", 64'(r_p0_rsp_valid), 64'd0);
      tick();
      checkOutput("rd_oeb_after", 64'(r_oeb), 64'd1);
      checkOutput("rd_r_p0_valid", 64'(r_p0_rsp_valid), 64'd1);
      checkOutput("rd_r_p0_rdata", 64'(r_p0_rsp_rdata), 64'hABCD_1234_5678);
      checkOutput("rd_r_p1_valid", 64'(r_p1_rsp_valid), 64'd0);
      checkOutput("rd_c_p0_late", 64'(c_p0_rsp_valid), 64'd0);
      tick();
      checkOutput("rd_r_p0_pulse", 64'(r_p0_rsp_valid), 64'd0);

      // Read / write / read on address 127: old data first, new data second
      applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 127, '0);
      checkOutput("raw_p1_ready", 64'(r_p1_ready), 64'd1);
      checkOutput("raw_p0_ready", 64'(r_p0_ready), 64'd0);
      tick();
      applyStimulus(1'b1, 1'b1, 127, 48'h1234_5678_9ABC, 1'b0, 1'b0, 0, '0);
      checkOutput("raw_wr_ready", 64'(r_p0_ready), 64'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 127, '0);
      checkOutput("raw_c_old_valid", 64'(c_p1_rsp_valid), 64'd1);
      checkOutput("raw_c_old_rdata", 64'(c_p1_rsp_rdata), 64'(initWord(127)));
      tick();
      idle();
      checkOutput("raw_r_old_valid", 64'(r_p1_rsp_valid), 64'd1);
      checkOutput("raw_r_old_rdata", 64'(r_p1_rsp_rdata), 64'(initWord(127)));
      checkOutput("raw_c_gap", 64'(c_p1_rsp_valid), 64'd0);
      tick();
      checkOutput("raw_c_new_valid", 64'(c_p1_rsp_valid), 64'd1);
      checkOutput("raw_c_new_rdata", 64'(c_p1_rsp_rdata), 64'h1234_5678_9ABC);
      tick();
      checkOutput("raw_r_new_valid", 64'(r_p1_rsp_valid), 64'd1);
      checkOutput("raw_r_new_rdata", 64'(r_p1_rsp_rdata), 64'h1234_5678_9ABC);
      checkOutput("raw_r_p0_quiet", 64'(r_p0_rsp_valid), 64'd0);
      tick();

      // Both ports read continuously for 6 cycles; p0 reads 20,21,22 and
      // p1 reads 40,41,42. Grant k goes to p0 when k is even.
      for (int k = 0; k < 10; k++) begin
         if (k < 6) begin
            applyStimulus(1'b1, 1'b0, 20 + (k + 1) / 2, '0, 1'b1, 1'b0, 40 + k / 2, '0);
            checkOutput($sformatf("rr_p0_ready_%0d", k), 64'(r_p0_ready), 64'((k % 2) == 0));
            checkOutput($sformatf("rr_p1_ready_%0d", k), 64'(r_p1_ready), 64'((k % 2) == 1));
         end else begin
            idle();
         end
         j = k - 2;
         exp_p0 = (j >= 0) && (j < 6) && ((j % 2) == 0);
         exp_p1 = (j >= 0) && (j < 6) && ((j % 2) == 1);
         exp_addr = ((j % 2) == 0) ? 20 + j / 2 : 40 + j / 2;
         checkOutput($sformatf("rr_c_p0_valid_%0d", k), 64'(c_p0_rsp_valid), 64'(exp_p0));
         checkOutput($sformatf("rr_c_p1_valid_%0d", k), 64'(c_p1_rsp_valid), 64'(exp_p1));
         if (exp_p0) checkOutput($sformatf("rr_c_p0_rdata_%0d", k), 64'(c_p0_rsp_rdata), 64'(initWord(exp_addr)));
         if (exp_p1) checkOutput($sformatf("rr_c_p1_rdata_%0d", k), 64'(c_p1_rsp_rdata), 64'(initWord(exp_addr)));
         j = k - 3;
         exp_p0 = (j >= 0) && (j < 6) && ((j % 2) == 0);
         exp_p1 = (j >= 0) && (j < 6) && ((j % 2) == 1);
         exp_addr = ((j % 2) == 0) ? 20 + j / 2 : 40 + j / 2;
         checkOutput($sformatf("rr_r_p0_valid_%0d", k), 64'(r_p0_rsp_valid), 64'(exp_p0));
         checkOutput($sformatf("rr_r_p1_valid_%0d", k), 64'(r_p1_rsp_valid), 64'(exp_p1));
         if (exp_p0) checkOutput($sformatf("rr_r_p0_rdata_%0d", k), 64'(r_p0_rsp_rdata), 64'(initWord(exp_addr)));
         if (exp_p1) checkOutput($sformatf("rr_r_p1_rdata_%0d", k), 64'(r_p1_rsp_rdata), 64'(initWord(exp_addr)));
         tick();
      end

      // Read in flight, then reset pulse: pins clear asynchronously, pointer
      // returns to p0 and the read never produces a response
      applyStimulus(1'b1, 1'b0, 3, '0, 1'b0, 1'b0, 0, '0);
      checkOutput("mid_p0_ready", 64'(r_p0_ready), 64'd1);
      tick();
      checkOutput("mid_csb_issued", 64'(r_csb), 64'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_csb", 64'(r_csb), 64'd1);
      checkOutput("mid_rst_web", 64'(r_web), 64'd1);
      checkOutput("mid_rst_a", 64'(r_a), 64'd0);
      checkOutput("mid_rst_i", 64'(r_i), 64'd0);
      checkOutput("mid_rst_oeb", 64'(c_oeb), 64'd1);
      applyStimulus(1'b1, 1'b0, 1, '0, 1'b1, 1'b0, 2, '0);
      checkOutput("mid_rst_ptr_p0", 64'(r_p0_ready), 64'd1);
      checkOutput("mid_rst_ptr_p1", 64'(r_p1_ready), 64'd0);
      idle();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput($sformatf("drop_oeb_%0d", k), 64'(r_oeb), 64'd1);
         checkOutput($sformatf("drop_r_rsp_%0d", k), 64'({r_p0_rsp_valid, r_p1_rsp_valid}), 64'd0);
         checkOutput($sformatf("drop_c_rsp_%0d", k), 64'({c_p0_rsp_valid, c_p1_rsp_valid}), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
